seg_scan_driver: RTL



---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_decode.sv | 29 ++
 rtl/seg_scan_driver.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns,
// code width and slot count.
package seg_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned SLOTS  = 8;

  // Segment order a,b,c,d,e,f,g,dp from MSB to LSB, active-high.
  localparam logic [7:0] SEG_BLANK  = 8'h00;
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6
  };
  localparam logic [7:0] SEG_CODE_A = 8'h12;
  localparam logic [7:0] SEG_CODE_B = 8'h28;
  localparam logic [7:0] SEG_ERR    = 8'h9E;

  localparam logic [CODE_W-1:0] CODE_BLANK = 4'hF;

endpackage

// File: rtl/seg_decode.sv
// Combinational display-code to segment-pattern lookup.
module seg_decode
  import seg_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [7:0]        seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (code)
      4'h0: seg = SEG_DIGIT[0];
      4'h1: seg = SEG_DIGIT[1];
      4'h2: seg = SEG_DIGIT[2];
      4'h3: seg = SEG_DIGIT[3];
      4'h4: seg = SEG_DIGIT[4];
      4'h5: seg = SEG_DIGIT[5];
      4'h6: seg = SEG_DIGIT[6];
      4'h7: seg = SEG_DIGIT[7];
      4'h8: seg = SEG_DIGIT[8];
      4'h9: seg = SEG_DIGIT[9];
      4'hA: seg = SEG_CODE_A;
      4'hB: seg = SEG_CODE_B;
      4'hC, 4'hD, 4'hE: seg = SEG_ERR;
      4'hF: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with double-buffered codes,
// anti-ghosting blank window, leading-zero suppression and blinking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIV          = 150,
  parameter int unsigned BLANK_CYC    = 2,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_data,
  input  logic        disp_load,
  input  logic [7:0]  lz_mask,
  input  logic [7:0]  blink_mask,
  output logic [2:0]  SEL,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam logic [15:0] CNT_MAX   = 16'(DIV - 1);
  localparam logic [15:0] BLANK_LEN = 16'(BLANK_CYC);
  localparam logic [7:0]  BLINK_MAX = 8'(BLINK_FRAMES - 1);
  localparam logic [31:0] CODES_RST = {SLOTS{CODE_BLANK}};

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] shadow_q, shadow_d, pend_q, pend_d;
  logic [7:0]  lz_sh_q, lz_sh_d, blink_sh_q, blink_sh_d;
  logic [7:0]  lz_pend_q, lz_pend_d, blink_pend_q, blink_pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic [7:0]  seg_q, seg_d;
  logic        frame_done_q, frame_done_d;

  logic              tick, boundary, blank;
  logic [CODE_W-1:0] code_nxt;
  logic [7:0]        seg_raw;

  assign tick     = (cnt_q == CNT_MAX);
  assign boundary = tick && (sel_q == 3'd7);

  always_comb begin
    cnt_d         = tick ? 16'd0 : cnt_q + 16'd1;
    sel_d         = tick ? sel_q + 3'd1 : sel_q;
    shadow_d      = shadow_q;
    lz_sh_d       = lz_sh_q;
    blink_sh_d    = blink_sh_q;
    pend_d        = pend_q;
    lz_pend_d     = lz_pend_q;
    blink_pend_d  = blink_pend_q;
    pend_valid_d  = pend_valid_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    frame_done_d  = 1'b0;

    if (boundary) begin
      frame_done_d = 1'b1;
      pend_valid_d = 1'b0;
      // A load landing on the boundary goes straight to shadow and wins
      // over anything still waiting in pending.
      if (disp_load) begin
        shadow_d   = disp_data;
        lz_sh_d    = lz_mask;
        blink_sh_d = blink_mask;
      end else if (pend_valid_q) begin
        shadow_d   = pend_q;
        lz_sh_d    = lz_pend_q;
        blink_sh_d = blink_pend_q;
      end
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d   = 8'd0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end else if (disp_load) begin
      pend_d       = disp_data;
      lz_pend_d    = lz_mask;
      blink_pend_d = blink_mask;
      pend_valid_d = 1'b1;
    end
  end

  // Output is computed from next-state values so seg tracks SEL every cycle.
  assign code_nxt = shadow_d[{sel_d, 2'b00} +: CODE_W];

  seg_decode u_decode (
    .code (code_nxt),
    .seg  (seg_raw)
  );

  always_comb begin
    blank = (cnt_d < BLANK_LEN)
         || (lz_sh_d[sel_d] && (code_nxt == 4'h0))
         || (blink_sh_d[sel_d] && blink_phase_d);
    seg_d = blank ? SEG_BLANK : seg_raw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q         <= 16'd0;
      sel_q         <= 3'd0;
      shadow_q      <= CODES_RST;
      lz_sh_q       <= 8'd0;
      blink_sh_q    <= 8'd0;
      pend_q        <= CODES_RST;
      lz_pend_q     <= 8'd0;
      blink_pend_q  <= 8'd0;
      pend_valid_q  <= 1'b0;
      blink_cnt_q   <= 8'd0;
      blink_phase_q <= 1'b0;
      seg_q         <= SEG_BLANK;
      frame_done_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      shadow_q      <= shadow_d;
      lz_sh_q       <= lz_sh_d;
      blink_sh_q    <= blink_sh_d;
      pend_q        <= pend_d;
      lz_pend_q     <= lz_pend_d;
      blink_pend_q  <= blink_pend_d;
      pend_valid_q  <= pend_valid_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign SEL        = sel_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule
